nn_inference_sequencer: RTL and testbench
=========================================

Name: nn_inference_sequencer

Overview:
- Top-level run controller for one inference pass through the network pipeline.
- Sequences NUM_LAYERS stages in order: the dense layers, then the final arg-max stage that emits digit/max/layer_done.
- Clears the stages before each run and holds each stage enabled until its layer_done arrives.
- Captures the final digit/max, reports done/error and run length to the host/testbench.

Parameters:
NUM_LAYERS, 3, number of sequenced stages; the last stage is the arg-max selector (min 1)
DATA_W, 16, width of signed max value from final stage
TIMEOUT_CYCLES, 4096, max cycles a stage may run without layer_done before error
CNT_W, 24, width of cycle_count

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a run; sampled only in IDLE
abort  in  1  cancel current run; returns to IDLE without done
layer_reset  out  1  one-cycle clear pulse to all stages at run start
layer_enable  out  NUM_LAYERS  per-stage enable, thermometer-coded
layer_done  in  NUM_LAYERS  per-stage completion level from each stage
digit_in  in  8  final stage winning index
max_in  in  DATA_W  final stage winning value, signed
busy  out  1  high from CLEAR through last RUN cycle
done  out  1  one-cycle pulse at run end (success or timeout)
error  out  1  sticky timeout flag, cleared on next accepted start or reset
result_digit  out  8  captured digit_in
result_max  out  DATA_W  captured max_in, signed
cycle_count  out  CNT_W  cycles of last run, saturating

Behaviour:
- Reset (synchronous): state=IDLE; all outputs 0, including the result registers and cycle_count.
- Reset has priority over abort, which has priority over all other inputs.
- IDLE:
  - start=1 -> CLEAR; error cleared; cycle_count cleared.
  - start while busy is ignored (not queued).
- CLEAR (1 cycle): layer_reset=1, layer_enable=0, busy=1 -> RUN with stage=0.
- RUN(stage k): layer_enable[i]=1 for all i<=k; upstream stages stay enabled so their outputs stay valid for downstream stages.
  - layer_done[k] sampled 1 -> if k<NUM_LAYERS-1: stage=k+1, stage timer=0; the new enable bit is high from the next cycle.
  - If k=NUM_LAYERS-1: go to FINISH.
  - layer_done[j] for j!=k is ignored.
- Stage timer increments each RUN cycle. If it reaches TIMEOUT_CYCLES-1 and layer_done[k] is 0 -> TIMEOUT.
  - If layer_done and the timeout limit coincide, done wins.
- FINISH (1 cycle): result_digit<=digit_in, result_max<=max_in (both sampled on this cycle's edge); done=1; busy=0; layer_enable=0; -> IDLE.
- TIMEOUT (1 cycle): done=1, error=1, busy=0, layer_enable=0; result registers keep their previous values; -> IDLE.
- abort in CLEAR/RUN: -> IDLE next cycle; enables 0, busy 0; no done pulse; error unchanged; results unchanged.
- cycle_count:
  - +1 for each CLEAR and RUN cycle; saturates at all-ones.
  - Frozen after the run; holds until the next accepted start.
- Latency:
  - start sampled at edge 0 -> layer_reset high in cycle 1, layer_enable[0] high from cycle 2.
  - Final layer_done sampled at edge t -> done high in cycle t+1.
- result_max is signed; captured bit-exact, no extension.
- NUM_LAYERS=1: CLEAR -> RUN(0) -> FINISH.

Test Plan:
- Normal run, NUM_LAYERS=3; TB stage models raise layer_done on the 5th enabled cycle of each stage; final stage drives digit_in=3, max_in=85.
  -> layer_reset one pulse; enables 001, 011, 111 in sequence; done single pulse; result_digit=3, result_max=85; cycle_count=16; error=0.
- Negative max: final stage drives max_in=-120 (16'hFF88), digit 7 -> result_max=16'hFF88, result_digit=7.
- Timeout, TIMEOUT_CYCLES=16: stage 1 never asserts done.
  -> done+error high exactly 16 RUN cycles after stage 1 entry; enables 0; results unchanged.
  -> a new start clears error.
- layer_done[2] forced high during stage 0, start pulsed mid-run -> both ignored; sequencing identical to the normal run.
- reset asserted in RUN stage 1 -> next cycle all outputs 0, state IDLE; abort in stage 2 -> no done pulse, busy 0, previous results retained.

Source files
------------

// File: rtl/nn_inference_sequencer.sv
// Run controller for one inference pass: clears the stage pipeline, enables stages
// one after another until each reports done, then captures the arg-max result.
module nn_inference_sequencer #(
  parameter int NUM_LAYERS     = 3,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 24
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  output logic                  layer_reset,
  output logic [NUM_LAYERS-1:0] layer_enable,
  input  logic [NUM_LAYERS-1:0] layer_done,
  input  logic [7:0]            digit_in,
  input  logic [DATA_W-1:0]     max_in,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [7:0]            result_digit,
  output logic [DATA_W-1:0]     result_max,
  output logic [CNT_W-1:0]      cycle_count
);

  localparam int STAGE_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;
  localparam int TIMER_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [STAGE_W-1:0] LAST_STAGE  = STAGE_W'(NUM_LAYERS - 1);
  localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_FINISH,
    S_TIMEOUT
  } state_t;

  state_t              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                error_q, error_d;
  logic [7:0]          result_digit_q, result_digit_d;
  logic [DATA_W-1:0]   result_max_q, result_max_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic                stage_done;
  logic [CNT_W-1:0]    cycle_count_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      stage_q        <= '0;
      timer_q        <= '0;
      error_q        <= 1'b0;
      result_digit_q <= '0;
      result_max_q   <= '0;
      cycle_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      stage_q        <= stage_d;
      timer_q        <= timer_d;
      error_q        <= error_d;
      result_digit_q <= result_digit_d;
      result_max_q   <= result_max_d;
      cycle_count_q  <= cycle_count_d;
    end
  end

  // Only the completion of the currently active stage advances the sequence.
  always_comb begin
    stage_done = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (STAGE_W'(i) == stage_q) stage_done = layer_done[i];
    end
  end

  assign cycle_count_inc = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);

  always_comb begin
    state_d        = state_q;
    stage_d        = stage_q;
    timer_d        = timer_q;
    error_d        = error_q;
    result_digit_d = result_digit_q;
    result_max_d   = result_max_q;
    cycle_count_d  = cycle_count_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_CLEAR;
          error_d       = 1'b0;
          cycle_count_d = '0;
        end
      end
      S_CLEAR: begin
        cycle_count_d = cycle_count_inc;
        stage_d       = '0;
        timer_d       = '0;
        state_d       = abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        cycle_count_d = cycle_count_inc;
        if (abort) begin
          state_d = S_IDLE;
        end else if (stage_done) begin
          // A done arriving on the timeout cycle still counts as success.
          if (stage_q == LAST_STAGE) begin
            state_d = S_FINISH;
          end else begin
            stage_d = stage_q + STAGE_W'(1);
            timer_d = '0;
          end
        end else if (timer_q == TIMER_LIMIT) begin
          state_d = S_TIMEOUT;
          error_d = 1'b1;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_FINISH: begin
        result_digit_d = digit_in;
        result_max_d   = max_in;
        state_d        = S_IDLE;
      end
      S_TIMEOUT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Upstream stages remain enabled so their outputs stay valid downstream.
  always_comb begin
    layer_enable = '0;
    if (state_q == S_RUN) begin
      for (int i = 0; i < NUM_LAYERS; i++) begin
        layer_enable[i] = (STAGE_W'(i) <= stage_q);
      end
    end
  end

  assign layer_reset  = (state_q == S_CLEAR);
  assign busy         = (state_q == S_CLEAR) || (state_q == S_RUN);
  assign done         = (state_q == S_FINISH) || (state_q == S_TIMEOUT);
  assign error        = error_q;
  assign result_digit = result_digit_q;
  assign result_max   = result_max_q;
  assign cycle_count  = cycle_count_q;

endmodule

// File: tb/tb_nn_inference_sequencer.sv
// Self-checking bench for nn_inference_sequencer: behavioural stage models, a table of
// runs with a result scoreboard, and hand sequences for abort and mid-run reset.
module tb_nn_inference_sequencer;

  localparam int NL = 3;
  localparam int DW = 16;
  localparam int TO = 16;
  localparam int CW = 24;

  logic          clk = 1'b0;
  logic          reset, start, abort;
  logic          layer_reset;
  logic [NL-1:0] layer_enable, layer_done;
  logic [7:0]    digit_in;
  logic [DW-1:0] max_in;
  logic          busy, done, error;
  logic [7:0]    result_digit;
  logic [DW-1:0] result_max;
  logic [CW-1:0] cycle_count;

  nn_inference_sequencer #(
    .NUM_LAYERS(NL), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .layer_reset(layer_reset), .layer_enable(layer_enable), .layer_done(layer_done),
    .digit_in(digit_in), .max_in(max_in), .busy(busy), .done(done), .error(error),
    .result_digit(result_digit), .result_max(result_max), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            mode;
    logic [7:0]    digit;
    logic [DW-1:0] maxv;
    logic [7:0]    exp_digit;
    logic [DW-1:0] exp_max;
    logic [CW-1:0] exp_count;
    logic          exp_error;
  } rec_t;

  int            checks = 0;
  int            errors = 0;
  rec_t          tv[7];
  rec_t          sb[$];
  rec_t          mon_r;
  logic [NL-1:0] enable_trace[$];
  logic [NL-1:0] stall_mask = '0;
  logic [NL-1:0] force_mask = '0;
  int            en_cnt[NL];
  int            reset_pulses = 0;
  int            done_pulses = 0;
  bit            done_prev = 1'b0;

  // Stage model: each stage reports done from its 5th enabled cycle onward.
  always @(posedge clk) begin
    for (int i = 0; i < NL; i++)
      en_cnt[i] <= (layer_enable[i] && !layer_reset) ? en_cnt[i] + 1 : 0;
  end

  always_comb begin
    layer_done = '0;
    for (int i = 0; i < NL; i++)
      layer_done[i] = force_mask[i] | (layer_enable[i] & ~stall_mask[i] & (en_cnt[i] >= 4));
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: pulse counters, enable history and scoreboard pop one cycle after done.
  always @(negedge clk) begin
    if (layer_reset) reset_pulses++;
    if (done) done_pulses++;
    if (enable_trace.size() == 0 || enable_trace[enable_trace.size()-1] != layer_enable)
      enable_trace.push_back(layer_enable);
    if (done_prev) begin
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_done", 32'd1, 32'd0);
      end else begin
        mon_r = sb.pop_front();
        checkOutput("sb_result_digit", 32'(result_digit), 32'(mon_r.exp_digit));
        checkOutput("sb_result_max", 32'(result_max), 32'(mon_r.exp_max));
        checkOutput("sb_cycle_count", 32'(cycle_count), 32'(mon_r.exp_count));
        checkOutput("sb_error", 32'(error), 32'(mon_r.exp_error));
      end
    end
    done_prev = done;
  end

  task automatic applyStimulus(input rec_t r);
    digit_in     = r.digit;
    max_in       = r.maxv;
    stall_mask   = (r.mode == 1) ? 3'b010 : 3'b000;
    force_mask   = '0;
    reset_pulses = 0;
    done_pulses  = 0;
    enable_trace.delete();
    sb.push_back(r);
    start = 1'b1;
  endtask

  task automatic checkIdleZero(input string tag);
    checkOutput({tag, "_layer_reset"}, 32'(layer_reset), 32'd0);
    checkOutput({tag, "_enable"}, 32'(layer_enable), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_error"}, 32'(error), 32'd0);
    checkOutput({tag, "_digit"}, 32'(result_digit), 32'd0);
    checkOutput({tag, "_max"}, 32'(result_max), 32'd0);
    checkOutput({tag, "_count"}, 32'(cycle_count), 32'd0);
  endtask

  task automatic runOne(input rec_t r);
    bit   got;
    int   s1, d;
    logic [31:0] packed_trace;
    applyStimulus(r);
    got = 1'b0;
    s1  = -1;
    d   = -1;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        checkOutput("clear_layer_reset", 32'(layer_reset), 32'd1);
        checkOutput("clear_busy", 32'(busy), 32'd1);
        checkOutput("clear_error", 32'(error), 32'd0);
      end
      if (s1 < 0 && layer_enable == 3'b011) s1 = cyc;
      if (done) begin
        got = 1'b1;
        d   = cyc;
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_enable", 32'(layer_enable), 32'd0);
        checkOutput("done_error", 32'(error), 32'(r.exp_error));
      end
      start = (r.mode == 2 && cyc == 3);
      if (r.mode == 2) force_mask = (layer_enable == 3'b001) ? 3'b100 : 3'b000;
    end
    start      = 1'b0;
    force_mask = '0;
    if (!got) begin
      checkOutput("run_done_seen", 32'd0, 32'd1);
      sb.delete();
    end else begin
      checkOutput("stage1_to_done", 32'(d - s1), (r.mode == 1) ? 32'd16 : 32'd10);
    end
    repeat (2) @(negedge clk);
    stall_mask = '0;
    packed_trace = '0;
    foreach (enable_trace[i]) packed_trace = (packed_trace << 4) | 32'(enable_trace[i]);
    checkOutput("enable_sequence", packed_trace, (r.mode == 1) ? 32'h0130 : 32'h01370);
    checkOutput("layer_reset_pulses", 32'(reset_pulses), 32'd1);
    checkOutput("done_pulses", 32'(done_pulses), 32'd1);
  endtask

  task automatic waitEnable(input logic [NL-1:0] val, input string name);
    bit ok = 1'b0;
    for (int cyc = 0; cyc < 100 && !ok; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (layer_enable == val) ok = 1'b1;
    end
    if (!ok) checkOutput(name, 32'd0, 32'd1);
  endtask

  initial begin
    tv[0] = '{0, 8'd3,   16'd85,    8'd3,   16'd85,    24'd16, 1'b0};
    tv[1] = '{0, 8'd7,   16'hFF88,  8'd7,   16'hFF88,  24'd16, 1'b0};
    tv[2] = '{0, 8'd0,   16'h7FFF,  8'd0,   16'h7FFF,  24'd16, 1'b0};
    tv[3] = '{0, 8'd255, 16'h8000,  8'd255, 16'h8000,  24'd16, 1'b0};
    tv[4] = '{1, 8'h55,  16'h1111,  8'd255, 16'h8000,  24'd22, 1'b1};
    tv[5] = '{0, 8'd9,   16'h04D2,  8'd9,   16'h04D2,  24'd16, 1'b0};
    tv[6] = '{2, 8'd1,   16'hFFFF,  8'd1,   16'hFFFF,  24'd16, 1'b0};

    reset    = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    digit_in = '0;
    max_in   = '0;
    repeat (2) @(negedge clk);
    checkIdleZero("reset");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      runOne(tv[i]);
      repeat (2) @(negedge clk);
    end

    // Abort during the last stage: no done pulse, previous result retained.
    digit_in    = 8'hAA;
    max_in      = 16'h5555;
    done_pulses = 0;
    start       = 1'b1;
    waitEnable(3'b111, "abort_wait_stage2");
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_enable", 32'(layer_enable), 32'd0);
    repeat (5) @(negedge clk);
    checkOutput("abort_done_pulses", 32'(done_pulses), 32'd0);
    checkOutput("abort_digit", 32'(result_digit), 32'(tv[6].exp_digit));
    checkOutput("abort_max", 32'(result_max), 32'(tv[6].exp_max));
    checkOutput("abort_error", 32'(error), 32'd0);

    // Reset during stage 1 clears everything on the next cycle.
    start = 1'b1;
    waitEnable(3'b011, "reset_wait_stage1");
    reset = 1'b1;
    @(negedge clk);
    checkIdleZero("midrun_reset");
    reset = 1'b0;
    repeat (3) @(negedge clk);

    checkOutput("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
